// File: rtl/move_scheduler_if.sv
// Request/command bundle between the three requesters, the engine and move_scheduler.
// The scheduler takes the slave view; whoever drives the requests and the engine ready takes the master view.
interface move_scheduler_if;
    logic       btn_valid;
    logic [2:0] btn_cmd;
    logic       uart_valid;
    logic [2:0] uart_cmd;
    logic [3:0] level;
    logic       pause;
    logic       eng_ready;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [1:0] cmd_src;
    logic       overrun;

    modport master (
        output btn_valid, btn_cmd, uart_valid, uart_cmd, level, pause, eng_ready,
        input  cmd_valid, cmd, cmd_src, overrun
    );

    modport slave (
        input  btn_valid, btn_cmd, uart_valid, uart_cmd, level, pause, eng_ready,
        output cmd_valid, cmd, cmd_src, overrun
    );
endinterface

// File: rtl/move_scheduler.sv
// Merges button, UART and gravity-timer requests into one valid/ready command stream
// with a one-cycle guard gap after every transfer.
module move_scheduler #(
    parameter int TICK_DIV    = 50000,
    parameter int BASE_PERIOD = 800,
    parameter int STEP        = 50,
    parameter int MIN_PERIOD  = 100
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    move_scheduler_if.slave  bus
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [19:0]    STEP_W     = 20'(STEP);
    localparam logic [19:0]    BASE_W     = 20'(BASE_PERIOD);
    localparam logic [19:0]    SPAN_W     = 20'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [15:0]    MIN_W      = 16'(MIN_PERIOD);

    localparam logic [2:0] CMD_SOFT = 3'd4;
    localparam logic [2:0] CMD_HARD = 3'd5;
    localparam logic [1:0] SRC_GRAV = 2'd0;
    localparam logic [1:0] SRC_BTN  = 2'd1;
    localparam logic [1:0] SRC_UART = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Codes 0 and 7 are not commands and never occupy a slot.
    function automatic logic cmd_ok(input logic [2:0] code);
        cmd_ok = (code != 3'd0) && (code != 3'd7);
    endfunction

    state_t         state_r, state_n;
    logic           cmd_valid_r, cmd_valid_n;
    logic [2:0]     cmd_r, cmd_n;
    logic [1:0]     src_r, src_n;
    logic           grant_s;

    logic           b_full_r, u_full_r, g_full_r;
    logic [2:0]     b_cmd_r, u_cmd_r;
    logic           rr_ptr_r;

    logic [PW-1:0]  presc_r;
    logic [15:0]    drop_r;
    logic [19:0]    step_lvl_s;
    logic [15:0]    period_s;
    logic           tick_s, expire_s, grav_clr_s;

    logic [1:0]     win_src_s;
    logic [2:0]     win_cmd_s;
    logic           any_pend_s, xfer_s;
    logic           b_str_s, u_str_s, b_clr_s, u_clr_s, b_free_s, u_free_s;

    assign any_pend_s = g_full_r | b_full_r | u_full_r;
    assign xfer_s     = (state_r == ST_ISSUE) & bus.eng_ready;
    assign grav_clr_s = xfer_s & ((cmd_r == CMD_SOFT) | (cmd_r == CMD_HARD));

    assign b_str_s  = bus.btn_valid & cmd_ok(bus.btn_cmd);
    assign u_str_s  = bus.uart_valid & cmd_ok(bus.uart_cmd);
    assign b_clr_s  = xfer_s & (src_r == SRC_BTN);
    assign u_clr_s  = xfer_s & (src_r == SRC_UART);
    // A slot being emptied by this cycle's transfer can take a new request.
    assign b_free_s = ~b_full_r | b_clr_s;
    assign u_free_s = ~u_full_r | u_clr_s;

    assign bus.overrun   = (b_str_s & ~b_free_s) | (u_str_s & ~u_free_s);
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd       = cmd_r;
    assign bus.cmd_src   = src_r;

    // Gravity period in time units for the current level, floored at MIN_PERIOD.
    always_comb begin
        step_lvl_s = STEP_W * {16'd0, bus.level};
        if (step_lvl_s >= SPAN_W) begin
            period_s = MIN_W;
        end else begin
            period_s = 16'(BASE_W - step_lvl_s);
        end
    end

    assign tick_s   = ~bus.pause & (presc_r == PRESC_LAST);
    assign expire_s = tick_s & (drop_r >= (period_s - 16'd1));

    // Time-unit prescaler and drop counter; frozen by pause, restarted by any drop transfer.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            presc_r <= '0;
            drop_r  <= 16'd0;
        end else if (grav_clr_s) begin
            presc_r <= '0;
            drop_r  <= 16'd0;
        end else if (!bus.pause) begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
            if (tick_s) begin
                drop_r <= expire_s ? 16'd0 : drop_r + 16'd1;
            end
        end
    end

    // Gravity slot: a drop transfer clearing it wins over a coincident expiry.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            g_full_r <= 1'b0;
        end else if (grav_clr_s) begin
            g_full_r <= 1'b0;
        end else if (expire_s) begin
            g_full_r <= 1'b1;
        end
    end

    // Button and UART slots.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            b_full_r <= 1'b0;
            b_cmd_r  <= 3'd0;
            u_full_r <= 1'b0;
            u_cmd_r  <= 3'd0;
        end else begin
            if (b_str_s && b_free_s) begin
                b_full_r <= 1'b1;
                b_cmd_r  <= bus.btn_cmd;
            end else if (b_clr_s) begin
                b_full_r <= 1'b0;
            end
            if (u_str_s && u_free_s) begin
                u_full_r <= 1'b1;
                u_cmd_r  <= bus.uart_cmd;
            end else if (u_clr_s) begin
                u_full_r <= 1'b0;
            end
        end
    end

    // Winner selection: gravity first, then round-robin between the user slots.
    always_comb begin
        win_src_s = SRC_GRAV;
        win_cmd_s = CMD_SOFT;
        if (g_full_r) begin
            win_src_s = SRC_GRAV;
            win_cmd_s = CMD_SOFT;
        end else if (b_full_r && u_full_r) begin
            if (rr_ptr_r) begin
                win_src_s = SRC_UART;
                win_cmd_s = u_cmd_r;
            end else begin
                win_src_s = SRC_BTN;
                win_cmd_s = b_cmd_r;
            end
        end else if (b_full_r) begin
            win_src_s = SRC_BTN;
            win_cmd_s = b_cmd_r;
        end else if (u_full_r) begin
            win_src_s = SRC_UART;
            win_cmd_s = u_cmd_r;
        end else begin
            win_src_s = SRC_GRAV;
            win_cmd_s = CMD_SOFT;
        end
    end

    // Round-robin pointer: after a user grant, point at the other user source.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            rr_ptr_r <= 1'b0;
        end else if (grant_s && (win_src_s != SRC_GRAV)) begin
            rr_ptr_r <= (win_src_s == SRC_BTN);
        end
    end

    // FSM state and registered command outputs.
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cmd_valid_r <= 1'b0;
            cmd_r       <= 3'd0;
            src_r       <= 2'd0;
        end else begin
            state_r     <= state_n;
            cmd_valid_r <= cmd_valid_n;
            cmd_r       <= cmd_n;
            src_r       <= src_n;
        end
    end

    // FSM next state: latch the winner in IDLE, hold it through ISSUE, one quiet GAP cycle.
    always_comb begin
        state_n     = state_r;
        cmd_valid_n = cmd_valid_r;
        cmd_n       = cmd_r;
        src_n       = src_r;
        grant_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_pend_s && !bus.pause) begin
                    state_n     = ST_ISSUE;
                    cmd_valid_n = 1'b1;
                    cmd_n       = win_cmd_s;
                    src_n       = win_src_s;
                    grant_s     = 1'b1;
                end else begin
                    state_n     = ST_IDLE;
                    cmd_valid_n = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (bus.eng_ready) begin
                    state_n     = ST_GAP;
                    cmd_valid_n = 1'b0;
                end else begin
                    state_n     = ST_ISSUE;
                    cmd_valid_n = 1'b1;
                end
            end
            ST_GAP: begin
                state_n     = ST_IDLE;
                cmd_valid_n = 1'b0;
            end
            default: begin
                state_n     = ST_IDLE;
                cmd_valid_n = 1'b0;
            end
        endcase
    end

endmodule
